// File: rtl/load_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : load_sequencer
// Description : Control FSM that executes one RISC-V integer load (opcode
//               0000011) end to end: decode, rs1 read, effective address,
//               memory request/acknowledge, lane extraction with sign/zero
//               extension and register-file write-back.
// Options     : MISALIGN_TRAP_EN - when defined, misaligned accesses raise a
//               one-cycle 'misaligned' pulse and are abandoned. When
//               undefined, the low address bits are cleared to force
//               natural alignment.
// Revision    : 1.0 - initial release
// ============================================================================
module load_sequencer #(
  parameter int WORDSIZE = 64,
  parameter int SIZE     = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [SIZE-1:0]     machine_instruction,
  output logic [4:0]          rf_rs1_addr,
  input  logic [WORDSIZE-1:0] rf_rs1_data,
  output logic                mem_req,
  output logic [WORDSIZE-1:0] mem_addr,
  output logic [1:0]          mem_size,
  input  logic                mem_ack,
  input  logic [WORDSIZE-1:0] mem_rdata,
  output logic                rf_we,
  output logic [4:0]          rf_rd_addr,
  output logic [WORDSIZE-1:0] rf_wdata,
  output logic                busy,
  output logic                illegal
`ifdef MISALIGN_TRAP_EN
  ,
  output logic                misaligned
`endif
);

  localparam logic [6:0] OPCODE_LOAD = 7'b0000011;
  localparam logic [2:0] FUNCT3_BAD  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_ADDR = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4
  } state_t;

  state_t state_q;
  state_t state_d;

  // Latched instruction and datapath registers
  logic [SIZE-1:0]     instr_q;
  logic [WORDSIZE-1:0] rs1_data_q;
  logic [WORDSIZE-1:0] mem_addr_q;
  logic [1:0]          mem_size_q;
  logic [WORDSIZE-1:0] wdata_q;
  logic                illegal_q;
`ifdef MISALIGN_TRAP_EN
  logic                misaligned_q;
`endif

  // Decoded fields of the latched instruction
  logic [11:0] imm;
  logic [4:0]  rs1;
  logic [2:0]  funct3;
  logic [4:0]  rd;

  assign imm    = instr_q[31:20];
  assign rs1    = instr_q[19:15];
  assign funct3 = instr_q[14:12];
  assign rd     = instr_q[11:7];

  // Legality of the instruction currently offered on the input port
  logic in_legal;
  assign in_legal = (machine_instruction[6:0] == OPCODE_LOAD) &&
                    (machine_instruction[14:12] != FUNCT3_BAD);

  // Effective address and the low-bit mask implied by the access size
  logic [WORDSIZE-1:0] eff_addr;
  logic [2:0]          low_mask;
  logic [WORDSIZE-1:0] addr_next;
  logic                addr_misaligned;

  assign eff_addr = rs1_data_q + {{(WORDSIZE-12){imm[11]}}, imm};

  // Bits that must be zero for a naturally aligned access of this size
  always_comb begin
    low_mask = 3'b000;
    case (funct3[1:0])
      2'd0:    low_mask = 3'b000;
      2'd1:    low_mask = 3'b001;
      2'd2:    low_mask = 3'b011;
      default: low_mask = 3'b111;
    endcase
  end

  assign addr_misaligned = |(eff_addr[2:0] & low_mask);

`ifdef MISALIGN_TRAP_EN
  // Misaligned accesses are trapped, so the address goes out unmodified
  assign addr_next = eff_addr;
`else
  // Misaligned accesses are silently forced onto the natural boundary
  assign addr_next = eff_addr & ~{{(WORDSIZE-3){1'b0}}, low_mask};
`endif

  // Lane extraction and extension of the returned doubleword
  logic [WORDSIZE-1:0] shifted;
  logic [WORDSIZE-1:0] load_value;

  assign shifted = mem_rdata >> {mem_addr_q[2:0], 3'b000};

  // Select the addressed bytes and sign- or zero-extend per funct3
  always_comb begin
    load_value = '0;
    case (funct3)
      3'b000:  load_value = {{(WORDSIZE-8){shifted[7]}},   shifted[7:0]};
      3'b001:  load_value = {{(WORDSIZE-16){shifted[15]}}, shifted[15:0]};
      3'b010:  load_value = {{(WORDSIZE-32){shifted[31]}}, shifted[31:0]};
      3'b011:  load_value = shifted;
      3'b100:  load_value = {{(WORDSIZE-8){1'b0}},  shifted[7:0]};
      3'b101:  load_value = {{(WORDSIZE-16){1'b0}}, shifted[15:0]};
      3'b110:  load_value = {{(WORDSIZE-32){1'b0}}, shifted[31:0]};
      default: load_value = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and state-decoded handshake outputs
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    mem_req     = 1'b0;
    rf_we       = 1'b0;
    busy        = 1'b1;
    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
        if (instr_valid && in_legal) begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        state_d = S_ADDR;
      end
      S_ADDR: begin
`ifdef MISALIGN_TRAP_EN
        if (addr_misaligned) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_MEM;
        end
`else
        state_d = S_MEM;
`endif
      end
      S_MEM: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        // x0 is hard-wired to zero, so its write is suppressed
        rf_we   = (rd != 5'd0);
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath captures: instruction, rs1 operand, address/size, load data
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q    <= '0;
      rs1_data_q <= '0;
      mem_addr_q <= '0;
      mem_size_q <= 2'd0;
      wdata_q    <= '0;
      illegal_q  <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      if ((state_q == S_IDLE) && instr_valid) begin
        instr_q   <= machine_instruction;
        illegal_q <= !in_legal;
      end
      if (state_q == S_READ) begin
        rs1_data_q <= rf_rs1_data;
      end
      if (state_q == S_ADDR) begin
        mem_addr_q <= addr_next;
        mem_size_q <= funct3[1:0];
      end
      if ((state_q == S_MEM) && mem_ack) begin
        wdata_q <= load_value;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  // One-cycle misalignment pulse raised when ADDR abandons the access
  always_ff @(posedge clk) begin
    if (reset) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= (state_q == S_ADDR) && addr_misaligned;
    end
  end

  assign misaligned = misaligned_q;
`endif

  assign rf_rs1_addr = rs1;
  assign rf_rd_addr  = rd;
  assign mem_addr    = mem_addr_q;
  assign mem_size    = mem_size_q;
  assign rf_wdata    = wdata_q;
  assign illegal     = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_sequencer
// Description : Directed, table-driven bench for load_sequencer with a few
//               hand-written multi-cycle sequences (illegal, misalign, reset).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] machine_instruction;
  logic [4:0]  rf_rs1_addr;
  logic [63:0] rf_rs1_data;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic [1:0]  mem_size;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_rd_addr;
  logic [63:0] rf_wdata;
  logic        busy;
  logic        illegal;
`ifdef MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  int checks = 0;
  int errors = 0;
  int we_count = 0;
  int req_count = 0;

  logic [63:0] regs [32];
  assign rf_rs1_data = regs[rf_rs1_addr];

  load_sequencer #(.WORDSIZE(64), .SIZE(32)) dut (
    .clk                 (clk),
    .reset               (reset),
    .instr_valid         (instr_valid),
    .instr_ready         (instr_ready),
    .machine_instruction (machine_instruction),
    .rf_rs1_addr         (rf_rs1_addr),
    .rf_rs1_data         (rf_rs1_data),
    .mem_req             (mem_req),
    .mem_addr            (mem_addr),
    .mem_size            (mem_size),
    .mem_ack             (mem_ack),
    .mem_rdata           (mem_rdata),
    .rf_we               (rf_we),
    .rf_rd_addr          (rf_rd_addr),
    .rf_wdata            (rf_wdata),
    .busy                (busy),
    .illegal             (illegal)
`ifdef MISALIGN_TRAP_EN
    ,
    .misaligned          (misaligned)
`endif
  );

  always #5 clk = ~clk;

  // Count register writes and request cycles seen on the ports
  always @(posedge clk) begin
    if (rf_we) we_count++;
    if (mem_req) req_count++;
  end

  typedef struct {
    logic [31:0] instr;
    logic [63:0] rdata;
    int          delay;
    logic [63:0] exp_addr;
    logic [1:0]  exp_size;
    logic        exp_we;
    logic [4:0]  exp_rd;
    logic [63:0] exp_wdata;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Run one load; entered and left at a falling edge with the DUT in IDLE
  task automatic run_vec(input vec_t v);
    chk("ready_idle", instr_ready, 1);
    instr_valid = 1'b1;
    machine_instruction = v.instr;
    @(negedge clk);
    instr_valid = 1'b0;
    machine_instruction = '0;
    chk("busy_read", busy, 1);
    chk("ready_read", instr_ready, 0);
    chk("rs1_addr", rf_rs1_addr, v.instr[19:15]);
    @(negedge clk);
    chk("req_in_addr", mem_req, 0);
    @(negedge clk);
    chk("req_mem", mem_req, 1);
    chk("mem_addr", mem_addr, v.exp_addr);
    chk("mem_size", mem_size, v.exp_size);
    for (int i = 0; i < v.delay; i++) begin
      @(negedge clk);
      chk("req_hold", mem_req, 1);
      chk("addr_hold", mem_addr, v.exp_addr);
    end
    mem_ack = 1'b1;
    mem_rdata = v.rdata;
    @(negedge clk);
    mem_ack = 1'b0;
    mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    chk("req_wb", mem_req, 0);
    chk("we_wb", rf_we, v.exp_we);
    chk("rd_addr", rf_rd_addr, v.exp_rd);
    if (v.exp_we) chk("wdata", rf_wdata, v.exp_wdata);
    @(negedge clk);
    chk("we_after", rf_we, 0);
    chk("ready_after", instr_ready, 1);
    chk("busy_after", busy, 0);
  endtask

  // Offer an instruction that must be rejected with a single illegal pulse
  task automatic run_illegal(input logic [31:0] ins);
    int req0;
    req0 = req_count;
    instr_valid = 1'b1;
    machine_instruction = ins;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("illegal_pulse", illegal, 1);
    chk("illegal_ready", instr_ready, 1);
    chk("illegal_busy", busy, 0);
    @(negedge clk);
    chk("illegal_drop", illegal, 0);
    chk("illegal_noreq", req_count - req0, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = '0;
    regs[1] = 64'h1000;
    regs[2] = 64'h2001;
    regs[3] = 64'h3000;
    regs[4] = 64'hFFFF_FFFF_FFFF_FFF8;

    //          instr         rdata                  dly addr     sz we  rd wdata
    vecs[0] = '{32'h0080B283, 64'h0123456789ABCDEF, 0, 64'h1008, 3, 1, 5, 64'h0123456789ABCDEF};
    vecs[1] = '{32'hFFF10303, 64'h1122334455667780, 0, 64'h2000, 0, 1, 6, 64'hFFFFFFFFFFFFFF80};
    vecs[2] = '{32'hFFF14303, 64'h1122334455667780, 1, 64'h2000, 0, 1, 6, 64'h0000000000000080};
    vecs[3] = '{32'h0001A003, 64'h0000000012345678, 3, 64'h3000, 2, 0, 0, 64'h0};
    vecs[4] = '{32'h00609403, 64'hBEEF000000000000, 0, 64'h1006, 1, 1, 8, 64'hFFFFFFFFFFFFBEEF};
    vecs[5] = '{32'h0060D403, 64'hBEEF000000000000, 2, 64'h1006, 1, 1, 8, 64'h000000000000BEEF};
    vecs[6] = '{32'h0040E483, 64'h8765432100000000, 0, 64'h1004, 2, 1, 9, 64'h0000000087654321};
    vecs[7] = '{32'h0040A483, 64'h8765432100000000, 0, 64'h1004, 2, 1, 9, 64'hFFFFFFFF87654321};
    vecs[8] = '{32'h00823503, 64'hCAFEF00D12345678, 1, 64'h0000, 3, 1, 10, 64'hCAFEF00D12345678};
    vecs[9] = '{32'h0020A383, 64'h00000000F0000001, 0, 64'h1000, 2, 1, 7, 64'hFFFFFFFFF0000001};

    reset = 1'b1;
    instr_valid = 1'b0;
    machine_instruction = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_req", mem_req, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_size", mem_size, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_rd", rf_rd_addr, 0);
    chk("rst_rs1", rf_rs1_addr, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

`ifdef MISALIGN_TRAP_EN
    // Misaligned LW must trap: pulse, no request, no write
    begin
      int req0;
      int we0;
      req0 = req_count;
      we0 = we_count;
      instr_valid = 1'b1;
      machine_instruction = vecs[9].instr;
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      chk("mis_quiet", misaligned, 0);
      @(negedge clk);
      chk("mis_pulse", misaligned, 1);
      chk("mis_idle", instr_ready, 1);
      @(negedge clk);
      chk("mis_drop", misaligned, 0);
      chk("mis_noreq", req_count - req0, 0);
      chk("mis_nowe", we_count - we0, 0);
    end
`else
    run_vec(vecs[9]);
`endif

    run_illegal(32'h00000013);
    run_illegal(32'h00007003);

    // Reset while waiting in MEM: request drops, late ack writes nothing
    begin
      int we0;
      we0 = we_count;
      instr_valid = 1'b1;
      machine_instruction = vecs[0].instr;
      @(negedge clk);
      instr_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_req_before", mem_req, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_req_after", mem_req, 0);
      chk("abort_ready", instr_ready, 1);
      chk("abort_busy", busy, 0);
      mem_ack = 1'b1;
      mem_rdata = 64'h5555_5555_5555_5555;
      @(negedge clk);
      mem_ack = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_idle", busy, 0);
      chk("abort_nowe", we_count - we0, 0);
    end

    // Normal load still works after the abort
    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_sequencer.md
Name: load_sequencer

Overview:
- Control FSM that executes one RISC-V load (I-type, opcode 0000011) end to end.
- Accepts a raw 32-bit instruction, splits it into imm/rs1/funct3/rd/opcode, reads rs1 from the register file and forms the effective address.
- Runs a request/acknowledge transaction on the data-memory port, then extracts, sign- or zero-extends and writes the loaded value back to rd.
- Sits between the fetch/issue stage and the register file / data memory.

Parameters:
WORDSIZE, 64, register and memory data width in bits (design supports 64 only).
SIZE, 32, instruction width in bits.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
instr_valid  input  1  machine_instruction is valid
instr_ready  output  1  sequencer can accept an instruction
machine_instruction  input  SIZE  raw instruction word
rf_rs1_addr  output  5  register-file read address (combinational read)
rf_rs1_data  input  WORDSIZE  register-file read data
mem_req  output  1  memory read request
mem_addr  output  WORDSIZE  byte address of access
mem_size  output  2  0=byte, 1=half, 2=word, 3=double
mem_ack  input  1  memory has returned data on mem_rdata this cycle
mem_rdata  input  WORDSIZE  aligned doubleword containing mem_addr, little-endian
rf_we  output  1  register-file write enable
rf_rd_addr  output  5  write address
rf_wdata  output  WORDSIZE  write data
busy  output  1  high in every state except IDLE
illegal  output  1  one-cycle pulse: rejected instruction

Behaviour:
- Clock clk; reset is synchronous and active-high (already decided).
- Reset: state=IDLE; instr_ready=1; mem_req=0, rf_we=0, illegal=0, busy=0; mem_addr, rf_wdata, rf_rd_addr, rf_rs1_addr=0; mem_size=0.
- States: IDLE, READ, ADDR, MEM, WB.
- IDLE:
  - instr_ready=1.
  - On instr_valid&instr_ready: latch instruction.
  - If opcode!=0000011 or funct3==111: pulse illegal next cycle, stay IDLE.
  - Otherwise go to READ.
- READ: rf_rs1_addr=latched rs1; capture rf_rs1_data at end of cycle; go to ADDR.
- ADDR:
  - addr = rs1_data + sign_extend(imm[11:0]), modulo 2^64 (wrap, no overflow flag).
  - mem_size = funct3[1:0]; go to MEM.
- MEM:
  - mem_req=1; mem_addr and mem_size held stable until mem_ack.
  - On the mem_ack cycle: capture mem_rdata, drop mem_req next cycle, go to WB.
  - mem_ack outside MEM is ignored.
- WB:
  - rf_we=1 for exactly one cycle, rf_rd_addr=rd.
  - If rd==0, rf_we stays 0, but WB is still visited.
  - Return to IDLE.
- Extraction: lane = addr[2:0] selects the starting byte.
  - funct3 000 LB, 001 LH, 010 LW: sign-extend.
  - 011 LD: full doubleword.
  - 100 LBU, 101 LHU, 110 LWU: zero-extend.
- Alignment without feature: low address bits below access size are cleared (half: bit0; word: [1:0]; double: [2:0]) before driving mem_addr and selecting the lane.
- Latency: accept at cycle T, READ T+1, ADDR T+2, MEM from T+3. With mem_ack in T+3: WB T+4, instr_ready=1 at T+5.
- instr_ready=0 in all non-IDLE states; instr_valid is ignored there.
- No memory timeout; MEM waits indefinitely.
- Reset mid-operation: next edge forces IDLE, mem_req drops and no rf_we is issued.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - Adds output misaligned (1 bit, reset 0).
  - In ADDR, if the address is not naturally aligned to the access size: pulse misaligned one cycle, issue no mem_req and no rf_we, return to IDLE.
- Undefined:
  - Port absent; the forced-alignment rule applies.

Test Plan:
- x1=0x1000, instr 0x0080B283 (LD x5,8(x1)), mem_ack 0 cycles late with rdata 0x0123456789ABCDEF -> mem_addr 0x1008, mem_size 3, rf_we at T+4, rd=5, rf_wdata 0x0123456789ABCDEF.
- x2=0x2001, instr 0xFFF10303 (LB x6,-1(x2)), rdata byte0=0x80 -> mem_addr 0x2000, rf_wdata 0xFFFFFFFFFFFFFF80; same with 0xFFF14303 (LBU) -> 0x0000000000000080.
- LW with rd=0, mem_ack delayed 3 cycles -> mem_req high 4 cycles with stable addr, rf_we never asserted, instr_ready returns.
- instr 0x00000013 (ADDI) -> illegal one-cycle pulse, no mem_req, instr_ready stays 1.
- LW at 0x1002 -> without MISALIGN_TRAP_EN: mem_addr 0x1000; with it: misaligned pulse, no mem_req, no rf_we.
- reset asserted while in MEM with mem_req=1 -> next cycle IDLE, mem_req=0; a late mem_ack causes no write.
